// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial receive path.
//   rx_state_t             - receiver FSM state encoding
//   SERIAL_DIVISOR_DEFAULT - clock cycles per bit (100 MHz / 115200 baud)
//   majority3              - 2-of-3 vote helper used when SERIAL_RX_MAJORITY_EN
//                            is defined
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  localparam int SERIAL_DIVISOR_DEFAULT = 868;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// serial_rx_sync: 2-FF synchroniser for the asynchronous serial line followed
// by a falling-edge detector. All flops reset to 1 (idle line level), so a
// line that is already high after reset never produces a spurious edge.
// Ports:
//   clk_in    in  system clock
//   rst_n_in  in  synchronous reset, active-low
//   async_in  in  asynchronous serial line
//   sync_out  out synchronised line level
//   fall_out  out high for one cycle when the synchronised line goes 1 -> 0
module serial_rx_sync
  import serial_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic async_in,
  output logic sync_out,
  output logic fall_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall_out = prev_q & ~sync_q;

endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver, LSB first. Recovers framed bytes from an
// asynchronous line and presents them on a valid/ready holding register.
// Framing errors and overruns are reported as one-cycle pulses.
// Optional feature: define SERIAL_RX_MAJORITY_EN to decide every bit by a
// 2-of-3 vote of the line at cnt==S-2, S-1 and S (default: single sample at S).
// Ports:
//   clk_in        in  system clock
//   rst_n_in      in  synchronous reset, active-low
//   rx_in         in  asynchronous serial line, idle high
//   ready_in      in  consumer accepts data_out this cycle
//   data_out      out received byte, stable while valid_out=1
//   valid_out     out data_out holds an unread byte
//   frame_err_out out one-cycle pulse: stop bit sampled low
//   overrun_out   out one-cycle pulse: byte completed while valid_out=1
module serial_rx
  import serial_pkg::*;
#(
  parameter int DIVISOR = SERIAL_DIVISOR_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rx_in,
  input  logic       ready_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       frame_err_out,
  output logic       overrun_out
);

  localparam logic [31:0] LAST = 32'(DIVISOR - 1);
  localparam logic [31:0] HALF = 32'(DIVISOR / 2);

  logic line;
  logic fall;

  serial_rx_sync u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .async_in (rx_in),
    .sync_out (line),
    .fall_out (fall)
  );

  rx_state_t   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  // Start bit is probed at its middle; data and stop bits one full period
  // after the previous sample, which keeps every probe near a bit centre.
  logic [31:0] sample_pt;
  logic        at_sample;
  logic        bit_val;

  assign sample_pt = (state_q == START) ? HALF : LAST;
  assign at_sample = (cnt_q == sample_pt);

`ifdef SERIAL_RX_MAJORITY_EN
  // Two early looks at the line; the third vote is the live value at S.
  logic vote_a_q;
  logic vote_b_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
    end else begin
      if (cnt_q == sample_pt - 32'd2) vote_a_q <= line;
      if (cnt_q == sample_pt - 32'd1) vote_b_q <= line;
    end
  end

  assign bit_val = majority3(vote_a_q, vote_b_q, line);
`else
  assign bit_val = line;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a delivery below in the same cycle overrides it.
    if (valid_q && ready_in) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (at_sample) begin
          cnt_d = '0;
          if (bit_val) begin
            state_d = IDLE;          // too short to be a start bit
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        if (at_sample) begin
          cnt_d          = '0;
          shift_d[idx_q] = bit_val;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (at_sample) begin
          cnt_d = '0;
          if (bit_val) begin
            state_d = IDLE;
            if (!valid_q || ready_in) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;      // keep the unread byte, drop the new one
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        // A held-low (break) line must not be mistaken for a new start bit.
        cnt_d = '0;
        if (line) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign frame_err_out = frame_err_q;
  assign overrun_out   = overrun_q;

endmodule
